// File: rtl/riscv_pkg.sv
// Shared types and widths for the RISC-V front end.
// Fetch entries carry the PC alongside the fetched word.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries.
// Flush empties it and rewinds both pointers in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem address and fetch queue.
// Decode sees only registered queue entries, never imem_rdata directly.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam logic [XLEN-1:0] PC_RST = {RESET_PC[31:2], 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop;
  logic            full, empty;
  logic [$clog2(FIFO_DEPTH):0] count_unused;
  fetch_entry_t    wr_ent, head;

  assign pop    = if_valid & if_ready;
  assign push   = !redirect_valid & (!full | pop);
  assign wr_ent = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_valid: pc_d = {redirect_pc[31:2], 2'b00};
      push:           pc_d = pc_q + XLEN'(INSTR_BYTES);
      default:        pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= PC_RST;
    else          pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wr_ent),
    .rdata_o (head),
    .count_o (count_unused),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head fields read as zero when empty so reset shows pc=0, pc+4=4.
  assign imem_addr   = pc_q;
  assign if_valid    = !empty;
  assign if_instr    = empty ? '0 : head.instr;
  assign if_pc       = empty ? '0 : head.pc;
  assign if_pc_plus4 = if_pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based fetch model.
// Memory word at byte address a is 32'h1000_0000 + a/4.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always_comb imem_rdata = memw(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          nvec = 0;
  int          nbad = 0;
  int          obs_hs = 0;

  function automatic logic e_valid();
    return mq.size() > 0;
  endfunction
  function automatic logic [31:0] e_pc();
    return (mq.size() > 0) ? mq[0].pc : 32'h0;
  endfunction
  function automatic logic [31:0] e_instr();
    return (mq.size() > 0) ? mq[0].instr : 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = {RPC[31:2], 2'b00};
  endtask

  // One clock: drive, advance the model across the edge, settle 1ns.
  task automatic cycle(input logic rdy, input logic rv,
                       input logic [31:0] tgt);
    bit   pop, push;
    ent_t e, dropped;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = tgt;
    @(posedge clk);
    if (if_valid && rdy) obs_hs++;
    pop = (mq.size() > 0) && rdy;
    if (rv) begin
      mq.delete();
      mpc = {tgt[31:2], 2'b00};
    end else begin
      push = (mq.size() < DEPTH) || pop;
      if (pop) dropped = mq.pop_front();
      if (push) begin
        e.pc    = mpc;
        e.instr = memw(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    #1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    nvec++; if (if_valid !== 1'b0) begin nbad++;
      $display("FAIL rst_valid got=%b exp=0", if_valid); end
    nvec++; if (if_pc !== 32'h0) begin nbad++;
      $display("FAIL rst_pc got=%h exp=0", if_pc); end
    nvec++; if (if_instr !== 32'h0) begin nbad++;
      $display("FAIL rst_instr got=%h exp=0", if_instr); end
    nvec++; if (if_pc_plus4 !== 32'h4) begin nbad++;
      $display("FAIL rst_pc4 got=%h exp=4", if_pc_plus4); end
    nvec++; if (imem_addr !== mpc) begin nbad++;
      $display("FAIL rst_addr got=%h exp=%h", imem_addr, mpc); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      nvec++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) ||
          if_instr !== 32'h1000_0000 + 32'(k)) begin
        nbad++;
        $display("FAIL free_run k=%0d got v=%b pc=%h i=%h exp pc=%h",
                 k, if_valid, if_pc, if_instr, 4 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    nvec++; if (imem_addr !== 32'h8) begin nbad++;
      $display("FAIL bp_addr got=%h exp=8", imem_addr); end
    nvec++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin nbad++;
      $display("FAIL bp_head got v=%b pc=%h exp pc=0", if_valid, if_pc); end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
        nbad++;
        $display("FAIL bp_drain k=%0d got v=%b pc=%h exp=%h",
                 k, if_valid, if_pc, 4 * k);
      end
      cycle(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_full();
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0043);
    nvec++; if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin nbad++;
      $display("FAIL redir_now got addr=%h v=%b exp 40/0",
               imem_addr, if_valid); end
    cycle(1'b0, 1'b0, 32'h0);
    nvec++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 ||
        if_pc_plus4 !== 32'h44 || if_instr !== 32'h1000_0010) begin
      nbad++;
      $display("FAIL redir_head got v=%b pc=%h p4=%h i=%h exp 40/44",
               if_valid, if_pc, if_pc_plus4, if_instr);
    end
  endtask

  task automatic test_redirect_pop();
    int hs0;
    cycle(1'b0, 1'b1, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    hs0 = obs_hs;
    cycle(1'b1, 1'b1, 32'h0000_0200);
    nvec++; if (obs_hs - hs0 !== 1) begin nbad++;
      $display("FAIL rp_hs got=%0d exp=1", obs_hs - hs0); end
    nvec++; if (if_valid !== 1'b0) begin nbad++;
      $display("FAIL rp_bubble got=%b exp=0", if_valid); end
    cycle(1'b1, 1'b0, 32'h0);
    nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin nbad++;
      $display("FAIL rp_target got v=%b pc=%h exp=200", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      nvec++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[k] ||
          if_pc_plus4 !== exp_pc[k] + 32'd4 ||
          if_instr !== memw(exp_pc[k])) begin
        nbad++;
        $display("FAIL wrap k=%0d got pc=%h p4=%h i=%h exp pc=%h",
                 k, if_pc, if_pc_plus4, if_instr, exp_pc[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (if_valid !== 1'b0 || imem_addr !== mpc ||
        if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
      nbad++;
      $display("FAIL arst got v=%b addr=%h pc=%h p4=%h",
               if_valid, imem_addr, if_pc, if_pc_plus4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0);
    nvec++; if (if_valid !== 1'b1 || if_pc !== RPC) begin nbad++;
      $display("FAIL arst_restart got v=%b pc=%h exp=%h",
               if_valid, if_pc, RPC); end
  endtask

  task automatic test_random();
    logic        rdy, rv;
    logic [31:0] tgt;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | tgt[3:0];
      cycle(rdy, rv, tgt);
      nvec++; if (if_valid !== e_valid()) begin nbad++;
        $display("FAIL rnd_valid n=%0d got=%b exp=%b",
                 n, if_valid, e_valid()); end
      nvec++; if (if_pc !== e_pc()) begin nbad++;
        $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, if_pc, e_pc()); end
      nvec++; if (if_instr !== e_instr()) begin nbad++;
        $display("FAIL rnd_instr n=%0d got=%h exp=%h",
                 n, if_instr, e_instr()); end
      nvec++; if (if_pc_plus4 !== e_pc() + 32'd4) begin nbad++;
        $display("FAIL rnd_pc4 n=%0d got=%h exp=%h",
                 n, if_pc_plus4, e_pc() + 32'd4); end
      nvec++; if (imem_addr !== mpc) begin nbad++;
        $display("FAIL rnd_addr n=%0d got=%h exp=%h",
                 n, imem_addr, mpc); end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mpc            = RPC;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
